// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared fetch types and constants for the LC-3 fetch slice
package lc3_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [WORD_W-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO with clear, full/empty and occupancy count
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates the full case from the empty case
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    // A pop on an empty queue is ignored even when a push lands the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and storage update; clear wins over push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LC-3 prefetching fetch sequencer; FETCH_PERF_EN adds perf counters
module fetch_unit
    import lc3_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(LC3_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             ir_valid,
    output logic [WIDTH-1:0] ir_data,
    output logic [WIDTH-1:0] ir_pc,
    input  logic             ir_pop,
    output logic [WIDTH-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall,
    output logic [15:0]      perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t       state;
    logic               outstanding;
    logic               drop;
    logic               push;
    logic               pop_req;
    logic               pop_ok;
    logic               credit;
    logic               q_full;
    logic               q_empty;
    logic [CW-1:0]      q_count;
    logic [CW-1:0]      count_next;
    logic [CW:0]        occ_next;
    logic [2*WIDTH-1:0] q_head;

    // Redirect discards any push or pop in its cycle
    assign push    = (state == WAIT) && mem_rvalid && !drop && !redirect;
    assign pop_req = ir_pop && !redirect;
    assign pop_ok  = pop_req && !q_empty;

    fetch_queue #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data ({mem_rdata, mem_addr}),
        .pop       (pop_req),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign ir_valid = !q_empty;
    assign ir_data  = q_head[2*WIDTH-1:WIDTH];
    assign ir_pc    = q_head[WIDTH-1:0];

    // Credit looks at post-edge occupancy so a pop re-opens fetch on the very next cycle
    always_comb begin
        count_next = q_count + CW'(push) - CW'(pop_ok);
        occ_next   = {1'b0, count_next} + (CW+1)'(outstanding && !mem_rvalid);
        credit     = run && (occ_next < (CW+1)'(DEPTH));
    end

    // Fetch FSM: request, wait for the single in-flight word, then decide whether to continue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc;
            mem_req     <= 1'b0;
            state       <= IDLE;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            // A word already accepted by memory must still be swallowed to keep responses in order
            if ((state == REQ && mem_gnt) || (state == WAIT && !mem_rvalid)) begin
                state       <= WAIT;
                outstanding <= 1'b1;
                drop        <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (credit) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        pc          <= pc + WIDTH'(1);
                        outstanding <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        outstanding <= 1'b0;
                        drop        <= 1'b0;
                        if (credit) begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters for fetched words, starved cycles and discarded responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_dropped <= '0;
        end else begin
            if (push && perf_fetched != '1) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (run && !ir_valid && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (state == WAIT && mem_rvalid && (drop || redirect) && perf_dropped != '1) begin
                perf_dropped <= perf_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;
    import lc3_pkg::*;

    logic        clk;
    logic        rst;
    logic        run;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_pop;
    logic [15:0] pc;

    int total = 0;
    int bad   = 0;

    int gnt_delay   = 0;
    int resp_lat    = 1;
    int grant_count;
    int rvalid_count;
    int age;
    int cnt;
    logic        busy;
    logic [15:0] raddr;

    fetch_entry_t sb[$];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_pop      (ir_pop),
        .pc          (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: word at addr holds addr-0x3000; grant after gnt_delay cycles, data resp_lat cycles later
    always @(negedge clk) begin
        if (rst) begin
            mem_gnt      = 1'b0;
            mem_rvalid   = 1'b0;
            mem_rdata    = 16'h0;
            busy         = 1'b0;
            cnt          = 0;
            age          = 0;
            raddr        = 16'h0;
            grant_count  = 0;
            rvalid_count = 0;
        end else begin
            mem_rvalid = 1'b0;
            if (busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_rvalid   = 1'b1;
                    mem_rdata    = raddr - 16'h3000;
                    busy         = 1'b0;
                    rvalid_count = rvalid_count + 1;
                end
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                if (age >= gnt_delay) begin
                    mem_gnt     = 1'b1;
                    busy        = 1'b1;
                    cnt         = resp_lat;
                    raddr       = mem_addr;
                    age         = 0;
                    grant_count = grant_count + 1;
                end else begin
                    age = age + 1;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        run         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        ir_pop      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic expect_word(input logic [15:0] addr);
        fetch_entry_t e;
        e.addr = addr;
        e.data = addr - 16'h3000;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        int n = 0;
        fetch_entry_t e;
        while (!ir_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_data"}, 32'(ir_data), 32'(e.data));
        check({tag, "_pc"}, 32'(ir_pc), 32'(e.addr));
        ir_pop = 1'b1;
        @(negedge clk);
        ir_pop = 1'b0;
    endtask

    task automatic wait_req(input string tag, output logic ok);
        int n = 0;
        while (!mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = mem_req;
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int   n;
        int   rv0;
        logic ok;

        rst = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; ir_pop = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'h3000);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ir_data", 32'(ir_data), 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);

        // Streaming fetch with 1-cycle memory: first word three cycles after run
        do_reset();
        gnt_delay = 0; resp_lat = 1;
        for (int i = 0; i < 4; i++) expect_word(16'h3000 + 16'(i));
        run = 1'b1;
        n = 0;
        while (!ir_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_cycle", 32'(n), 32'd3);
        for (int i = 0; i < 4; i++) pop_check("stream");

        // No pops: exactly DEPTH grants then park; a single pop resumes at 3004
        do_reset();
        for (int i = 0; i < 4; i++) expect_word(16'h3000 + 16'(i));
        run = 1'b1;
        repeat (30) @(negedge clk);
        check("full_grants", 32'(grant_count), 32'd4);
        check("full_req_idle", 32'(mem_req), 32'd0);
        pop_check("full_pop");
        wait_req("resume", ok);
        if (ok) check("resume_addr", 32'(mem_addr), 32'h3004);
        for (int i = 0; i < 3; i++) pop_check("full_drain");

        // Redirect while waiting on 3001: dropped response gates the next request
        do_reset();
        resp_lat = 3;
        run = 1'b1;
        n = 0;
        while (pc != 16'h3002 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("redir_reach_wait", 32'(pc), 32'h3002);
        rv0 = rvalid_count;
        redirect = 1'b1; redirect_pc = 16'h4000;
        @(negedge clk);
        redirect = 1'b0;
        sb.delete();
        expect_word(16'h4000);
        expect_word(16'h4001);
        wait_req("redir_req", ok);
        if (ok) begin
            check("redir_addr", 32'(mem_addr), 32'h4000);
            check("redir_after_drop", 32'(rvalid_count - rv0), 32'd1);
        end
        n = 0;
        while (mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("redir_pc_after_gnt", 32'(pc), 32'h4001);
        pop_check("redir_pop");
        pop_check("redir_pop");

        // Grant delayed three cycles: request held stable four cycles, one pc increment
        do_reset();
        gnt_delay = 3; resp_lat = 1;
        expect_word(16'h3000);
        run = 1'b1;
        wait_req("slow_req", ok);
        n = 0;
        while (mem_req && n < 20) begin
            check("slow_addr_stable", 32'(mem_addr), 32'h3000);
            @(negedge clk);
            n++;
        end
        check("slow_req_cycles", 32'(n), 32'd4);
        check("slow_pc", 32'(pc), 32'h3001);
        pop_check("slow_pop");

        // Address wrap from FFFF to 0000
        do_reset();
        gnt_delay = 0; resp_lat = 1;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        check("wrap_pc_load", 32'(pc), 32'hFFFF);
        expect_word(16'hFFFF);
        expect_word(16'h0000);
        run = 1'b1;
        pop_check("wrap_pop");
        pop_check("wrap_pop");

        // Reset asserted mid-WAIT returns to reset state at once
        do_reset();
        resp_lat = 3;
        run = 1'b1;
        n = 0;
        while (pc != 16'h3001 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_wait", 32'(pc), 32'h3001);
        #1 rst = 1'b1;
        #1;
        check("midrst_ir_valid", 32'(ir_valid), 32'd0);
        check("midrst_pc", 32'(pc), 32'h3000);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised LC-3 instruction fetch sequencer that replaces the hard-wired single-word "load IR" step in control.
- Owns the PC and issues word reads to a variable-latency memory port through a req/valid handshake.
- Buffers fetched instructions in a DEPTH-entry prefetch queue. Control pops the queue to load IR.
- Supports branch/JMP redirect with flush of queued and in-flight words.

Parameters:
- WIDTH, 16: instruction/address word width. PC and addresses wrap modulo 2^WIDTH.
- DEPTH, 4: prefetch queue entries, power of two, >= 2.
- RESET_PC, 16'h3000: PC value after reset.

Ports:
- clk  in  1: clock, all state updates on posedge.
- rst  in  1: asynchronous active-high reset.
- run  in  1: fetch enable. When 0, no new memory requests are issued; queue and in-flight request are kept.
- redirect  in  1: one-cycle pulse; load PC from redirect_pc and flush.
- redirect_pc  in  WIDTH: new fetch address.
- mem_req  out  1: read request, held until accepted.
- mem_addr  out  WIDTH: request address, stable while mem_req=1.
- mem_gnt  in  1: request accepted this cycle (mem_req & mem_gnt).
- mem_rvalid  in  1: read data valid, one per accepted request, in order.
- mem_rdata  in  WIDTH: read data.
- ir_valid  out  1: queue head valid.
- ir_data  out  WIDTH: queue head instruction.
- ir_pc  out  WIDTH: address of queue head (PC+1 semantics are the consumer's job).
- ir_pop  in  1: consume head. Ignored when ir_valid=0.
- pc  out  WIDTH: next address to request.

Behaviour:
- Reset values: pc=RESET_PC, mem_req=0, mem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, queue empty, state=IDLE, outstanding=0.
- Outstanding limit: at most one request in flight, so at most DEPTH queued plus one in flight is never exceeded.
- Credit rule: a request issues only if occupancy + outstanding < DEPTH.
- FSM states:
  - IDLE: go to REQ when run=1 and credit is available. Otherwise stay.
  - REQ: mem_req=1, mem_addr=pc. On mem_gnt: pc<=pc+1 (wrap), outstanding=1, go to WAIT.
  - WAIT: on mem_rvalid, push {mem_rdata, addr}. Then go to REQ if run and credit are available, else IDLE. A response on the same cycle as a grant is impossible (min latency 1).
- Throughput: with 1-cycle grant and 1-cycle rvalid, one word every 2 cycles. First ir_valid is 3 cycles after run rises from reset.
- Queue push and pop in the same cycle: occupancy unchanged; empty queue with push+pop is not bypassed (pop ignored).
- ir_data/ir_pc come from registered queue head; pop takes effect at the posedge.
- Redirect has priority over all events in that cycle:
  - queue cleared and pc<=redirect_pc.
  - If in REQ with no grant: mem_req drops next cycle, then the FSM re-enters REQ with the new address.
  - If in REQ with grant that cycle, or in WAIT: the pending response is marked drop. A drop response is discarded, not pushed, and clears outstanding.
  - Push and pop in the redirect cycle are discarded.
- Redirect during a dropped wait: a new request is not issued until the dropped response returns (preserves in-order matching).
- run deassert mid-WAIT: response is still accepted and pushed, then IDLE.
- Full queue: FSM parks in IDLE. It resumes the cycle after a pop frees credit.
- rst asserted mid-operation: immediate return to reset values. Memory is responsible for abandoning any outstanding read.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetched (32-bit count of words pushed), perf_stall (32-bit count of cycles with ir_valid=0 and run=1) and perf_dropped (16-bit count of discarded responses). All reset to 0 and saturate at max.
- Not defined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- lc3_pkg: WIDTH-independent fetch_state_t enum {IDLE, REQ, WAIT}; LC3_RESET_PC constant; fetch_entry_t struct {data, addr} parametrised via localparam WORD_W=16.
- Sub-module fetch_queue: synchronous FIFO with DEPTH, push, pop, clear, full, empty and count. Wrap pointers with an extra MSB to distinguish full/empty.

Test Plan:
- Reset, run=1, mem fixed 1-cycle latency, mem[3000..3003]=0..3 -> ir pops 0,1,2,3 with ir_pc 3000..3003; first ir_valid at cycle 3.
- No pops, DEPTH=4 -> exactly 4 grants, then mem_req stays 0. One pop -> next request at 3004.
- Redirect to 16'h4000 while in WAIT for 3001 -> 3001 data dropped, next ir_pc=4000, pc=4001 after grant; perf_dropped=1 with FETCH_PERF_EN.
- mem_gnt delayed 3 cycles -> mem_req and mem_addr held stable for all 4 cycles, single pc increment.
- PC=16'hFFFF fetch -> next mem_addr=16'h0000 (wrap).
- Assert rst while in WAIT -> next cycle ir_valid=0, pc=3000, mem_req=0.
